// File: rtl/mod_counter_pkg.sv
// Shared definitions for the modulo counter and its prescaler.
// Latency: n/a (constants and a compile-time helper only).
// Backpressure: n/a.
//
// Contents:
//   MODE_WRAP / MODE_SAT : boundary behaviour selectors for mod_counter
//   presc_width()        : bit width of the prescaler phase counter
package counter_pkg;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    // Phase counter covers 0..prescale-1, so clog2(prescale) bits suffice.
    // A single bit is kept even for prescale=1 so the register is never
    // zero-width.
    function automatic int presc_width(input int prescale);
        if (prescale <= 1) begin
            return 1;
        end
        return $clog2(prescale);
    endfunction

endpackage

// File: rtl/count_prescaler.sv
// Clock-enable prescaler: emits one step per PRESCALE enabled clk cycles.
// Latency: step is combinational from en and the registered phase (0 cycles).
// Backpressure: none; en low freezes the phase, restart discards it.
//
// Ports:
//   clk     : rising-edge clock
//   rst     : synchronous active-low reset, clears the phase
//   en      : advance the phase on this edge
//   restart : synchronous phase clear (clr|load from the parent)
//   step    : high when this enabled edge completes an interval
module count_prescaler
    import counter_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic restart,
    output logic step
);

    localparam int             PW   = presc_width(PRESCALE);
    localparam logic [PW-1:0]  LAST = PW'(PRESCALE - 1);
    localparam logic [PW-1:0]  ONE  = PW'(1);

    logic [PW-1:0] phase;

    // With PRESCALE=1, LAST is 0 and phase never leaves 0, so step == en.
    assign step = en && (phase == LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            phase <= '0;
        end else if (restart) begin
            phase <= '0;
        end else if (en) begin
            phase <= (phase == LAST) ? '0 : phase + ONE;
        end
    end

endmodule

// File: rtl/mod_counter.sv
// Modulo up/down counter with prescaler, load/clear, wrap or saturate mode.
// Latency: 1 clk from the stepping edge to dout/tc/ovf (all registered).
// Backpressure: none; en low holds the count and the prescaler phase.
//
// Ports:
//   clk, rst          : rising-edge clock, synchronous active-low reset
//   en, up            : count enable and direction (1 = up)
//   clr, load         : synchronous clear / load (clr has priority)
//   load_val          : load value, clamped to MAX_VAL
//   dout, tc, ovf     : count, one-cycle terminal-count pulse, sticky overflow
module mod_counter
    import counter_pkg::*;
#(
    parameter int              WIDTH    = 8,
    parameter longint unsigned MAX_VAL  = (64'd1 << WIDTH) - 64'd1,
    parameter int              MODE     = MODE_WRAP,
    parameter int              PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] dout,
    output logic             tc,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    logic             step;
    logic             at_bound;
    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH-1:0] next_val;

    count_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .restart (clr | load),
        .step    (step)
    );

    assign load_clamped = (load_val > MAXV) ? MAXV : load_val;

    // Boundary depends on direction: MAX_VAL going up, 0 going down.
    assign at_bound = up ? (dout == MAXV) : (dout == '0);

    always_comb begin
        next_val = dout;
        if (at_bound) begin
            if (MODE == MODE_SAT) begin
                next_val = dout;
            end else begin
                next_val = up ? '0 : MAXV;
            end
        end else begin
            next_val = up ? dout + ONE : dout - ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            dout <= '0;
            tc   <= 1'b0;
            ovf  <= 1'b0;
        end else if (clr) begin
            dout <= '0;
            tc   <= 1'b0;
            ovf  <= 1'b0;
        end else if (load) begin
            dout <= load_clamped;
            tc   <= 1'b0;
        end else if (step) begin
            dout <= next_val;
            tc   <= at_bound;
            if (at_bound) begin
                ovf <= 1'b1;
            end
        end else begin
            tc <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mod_counter.sv
// Self-checking bench: three counter configurations driven in parallel
// (WIDTH=4, MAX_VAL=9: wrap, saturate, and wrap with PRESCALE=3) compared
// every cycle against an arithmetic reference model.
module tb_mod_counter;
    import counter_pkg::*;

    logic       clk;
    logic       rst;
    logic       en;
    logic       up;
    logic       clr;
    logic       load;
    logic [3:0] load_val;

    logic [3:0] dout_w, dout_s, dout_p;
    logic       tc_w, tc_s, tc_p;
    logic       ovf_w, ovf_s, ovf_p;

    int passed = 0;
    int total  = 0;

    // Reference model state per configuration: 0 = wrap, 1 = sat, 2 = presc.
    int m_max [3] = '{9, 9, 9};
    int m_sat [3] = '{0, 1, 0};
    int m_ps  [3] = '{1, 1, 3};
    int m_cnt [3];
    int m_ph  [3];
    int m_tc  [3];
    int m_ovf [3];

    mod_counter #(.WIDTH(4), .MAX_VAL(9), .MODE(MODE_WRAP), .PRESCALE(1)) u_wrap (
        .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(load_val), .dout(dout_w), .tc(tc_w), .ovf(ovf_w)
    );

    mod_counter #(.WIDTH(4), .MAX_VAL(9), .MODE(MODE_SAT), .PRESCALE(1)) u_sat (
        .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(load_val), .dout(dout_s), .tc(tc_s), .ovf(ovf_s)
    );

    mod_counter #(.WIDTH(4), .MAX_VAL(9), .MODE(MODE_WRAP), .PRESCALE(3)) u_pre (
        .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(load_val), .dout(dout_p), .tc(tc_p), .ovf(ovf_p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // One clock edge of the specified behaviour, for every configuration.
    task automatic model_edge();
        for (int i = 0; i < 3; i++) begin
            if (!rst) begin
                m_cnt[i] = 0; m_ph[i] = 0; m_tc[i] = 0; m_ovf[i] = 0;
            end else if (clr) begin
                m_cnt[i] = 0; m_ph[i] = 0; m_tc[i] = 0; m_ovf[i] = 0;
            end else if (load) begin
                m_cnt[i] = (int'(load_val) > m_max[i]) ? m_max[i] : int'(load_val);
                m_ph[i]  = 0;
                m_tc[i]  = 0;
            end else if (en && ((m_ph[i] + 1) % m_ps[i] == 0)) begin
                m_ph[i] = 0;
                if (up) begin
                    m_tc[i]  = (m_cnt[i] == m_max[i]) ? 1 : 0;
                    m_cnt[i] = (m_tc[i] && m_sat[i] != 0) ? m_max[i]
                                                           : (m_cnt[i] + 1) % (m_max[i] + 1);
                end else begin
                    m_tc[i]  = (m_cnt[i] == 0) ? 1 : 0;
                    m_cnt[i] = (m_tc[i] && m_sat[i] != 0) ? 0
                                                           : (m_cnt[i] + m_max[i]) % (m_max[i] + 1);
                end
                if (m_tc[i] != 0) m_ovf[i] = 1;
            end else begin
                if (en) m_ph[i] = m_ph[i] + 1;
                m_tc[i] = 0;
            end
        end
    endtask

    task automatic check_all();
        check("wrap_dout", 32'(dout_w), 32'(m_cnt[0]));
        check("wrap_tc",   32'(tc_w),   32'(m_tc[0]));
        check("wrap_ovf",  32'(ovf_w),  32'(m_ovf[0]));
        check("sat_dout",  32'(dout_s), 32'(m_cnt[1]));
        check("sat_tc",    32'(tc_s),   32'(m_tc[1]));
        check("sat_ovf",   32'(ovf_s),  32'(m_ovf[1]));
        check("pre_dout",  32'(dout_p), 32'(m_cnt[2]));
        check("pre_tc",    32'(tc_p),   32'(m_tc[2]));
        check("pre_ovf",   32'(ovf_p),  32'(m_ovf[2]));
    endtask

    // Inputs change only at posedge+1, so DUT and model see the same values.
    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            model_edge();
            #1;
            check_all();
        end
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; up = 1'b1; clr = 1'b0; load = 1'b0; load_val = 4'd0;
        for (int i = 0; i < 3; i++) begin
            m_cnt[i] = 0; m_ph[i] = 0; m_tc[i] = 0; m_ovf[i] = 0;
        end
        tick(2);
        check("reset_dout", 32'(dout_w), 32'd0);
        check("reset_ovf",  32'(ovf_w),  32'd0);

        // Five steps, then a single reset edge.
        rst = 1'b1; en = 1'b1; up = 1'b1;
        tick(5);
        check("pre_reset_dout", 32'(dout_w), 32'd5);
        rst = 1'b0;
        tick(1);
        check("midrun_reset_dout", 32'(dout_w), 32'd0);
        check("midrun_reset_tc",   32'(tc_w),   32'd0);

        // Twelve up-steps: wrap shows 1..9,0,1,2; saturate holds 9.
        rst = 1'b1;
        tick(9);
        check("wrap_at_max", 32'(dout_w), 32'd9);
        tick(1);
        check("wrap_to_zero", 32'(dout_w), 32'd0);
        check("wrap_tc_pulse", 32'(tc_w), 32'd1);
        check("sat_hold_tc", 32'(tc_s), 32'd1);
        tick(2);
        check("wrap_after12", 32'(dout_w), 32'd2);
        check("wrap_tc_gone", 32'(tc_w), 32'd0);
        check("wrap_ovf_sticky", 32'(ovf_w), 32'd1);
        check("sat_after12", 32'(dout_s), 32'd9);
        check("pre_after12", 32'(dout_p), 32'd4);

        // Clear, then step down from 0.
        en = 1'b0; clr = 1'b1;
        tick(1);
        clr = 1'b0; en = 1'b1; up = 1'b0;
        tick(1);
        check("down_wrap", 32'(dout_w), 32'd9);
        check("down_wrap_tc", 32'(tc_w), 32'd1);
        check("sat_down_hold", 32'(dout_s), 32'd0);
        check("sat_down_tc", 32'(tc_s), 32'd1);

        // Clamped load keeps ovf, clear drops it.
        en = 1'b0; load = 1'b1; load_val = 4'd15;
        tick(1);
        check("load_clamp", 32'(dout_w), 32'd9);
        check("load_keeps_ovf", 32'(ovf_w), 32'd1);
        load = 1'b0; clr = 1'b1;
        tick(1);
        check("clr_ovf", 32'(ovf_w), 32'd0);

        // Prescaler: interval, en gaps, load discarding a partial count.
        clr = 1'b0; en = 1'b1; up = 1'b1;
        tick(3);
        check("pre_first_step", 32'(dout_p), 32'd1);
        tick(1);
        en = 1'b0;
        tick(2);
        en = 1'b1;
        tick(1);
        check("pre_gap_no_step", 32'(dout_p), 32'd1);
        tick(1);
        check("pre_gap_delayed", 32'(dout_p), 32'd2);
        tick(2);
        load = 1'b1; load_val = 4'd4;
        tick(1);
        load = 1'b0;
        tick(2);
        check("pre_load_restart_hold", 32'(dout_p), 32'd4);
        tick(1);
        check("pre_load_restart_step", 32'(dout_p), 32'd5);

        // clr beats load; reset beats load.
        load = 1'b1; load_val = 4'd5; en = 1'b0;
        tick(1);
        clr = 1'b1; load = 1'b1; en = 1'b1;
        tick(1);
        check("clr_over_load", 32'(dout_w), 32'd0);
        clr = 1'b0; load = 1'b1; load_val = 4'd7;
        tick(1);
        rst = 1'b0;
        tick(1);
        check("rst_over_load", 32'(dout_w), 32'd0);
        rst = 1'b1; load = 1'b0;

        // Randomised traffic against the model.
        for (int k = 0; k < 400; k++) begin
            rst      = ($urandom_range(0, 59) != 0);
            clr      = ($urandom_range(0, 24) == 0);
            load     = ($urandom_range(0, 11) == 0);
            en       = ($urandom_range(0, 3) != 0);
            up       = ($urandom_range(0, 4) != 0) ? (k % 80 < 40) : 1'($urandom_range(0, 1));
            load_val = 4'($urandom_range(0, 15));
            tick(1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
